// File: rtl/sobel_pkg.sv
// Shared widths and mode encodings for the Sobel stream pipeline.
package sobel_pkg;

    typedef enum logic {
        MAG_SQRT = 1'b0,
        MAG_L1   = 1'b1
    } mag_mode_e;

    function automatic int grad_width(input int pix_w);
        return pix_w + 4;
    endfunction

    function automatic int sq_width(input int pix_w);
        return 2 * pix_w + 7;
    endfunction

    function automatic int mag_width(input int pix_w);
        return pix_w + 4;
    endfunction

    function automatic int root_width(input int sq_w);
        return (sq_w + 1) / 2;
    endfunction

endpackage

// File: rtl/sobel_isqrt.sv
// Combinational restoring integer square root: root = floor(sqrt(radicand)).
module sobel_isqrt #(
    parameter int SQ_W   = 23,
    parameter int ROOT_W = (SQ_W + 1) / 2
) (
    input  logic [SQ_W-1:0]   radicand,
    output logic [ROOT_W-1:0] root
);

    logic [2*ROOT_W-1:0] padded;
    logic [ROOT_W+1:0]   rem;
    logic [ROOT_W+1:0]   trial;
    logic [ROOT_W-1:0]   acc;

    // Two radicand bits per step; the remainder never exceeds 2*acc, so ROOT_W+2 bits suffice.
    always_comb begin
        padded = (2*ROOT_W)'(radicand);
        rem    = '0;
        trial  = '0;
        acc    = '0;
        for (int i = ROOT_W - 1; i >= 0; i--) begin
            rem   = {rem[ROOT_W-1:0], padded[2*i +: 2]};
            trial = {acc, 2'b01};
            if (rem >= trial) begin
                rem = rem - trial;
                acc = {acc[ROOT_W-2:0], 1'b1};
            end else begin
                acc = {acc[ROOT_W-2:0], 1'b0};
            end
        end
        root = acc;
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a sliding window and a
// four-stage gradient/magnitude pipeline under one global valid/ready stall.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int MAG_MODE = 0,
    parameter int INVERT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             thr_en,
    input  logic [PIX_W-1:0] thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic [PIX_W-1:0] out_pix
);

    localparam int GRAD_W = grad_width(PIX_W);
    localparam int SQ_W   = sq_width(PIX_W);
    localparam int MAG_W  = mag_width(PIX_W);
    localparam int ROOT_W = root_width(SQ_W);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam bit USE_L1 = (MAG_MODE == int'(MAG_L1));
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    logic stall;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    logic [COL_W-1:0] col_cnt, cur_col, next_col;
    logic [ROW_W-1:0] row_cnt, cur_row, next_row;
    logic             col_last, row_last, win_ok, win_first, win_last;

    // An accepted in_sof overrides the counters so the stream can resync at any point.
    always_comb begin
        cur_col   = in_sof ? '0 : col_cnt;
        cur_row   = in_sof ? '0 : row_cnt;
        col_last  = (cur_col == COL_W'(IMG_W - 1));
        row_last  = (cur_row == ROW_W'(IMG_H - 1));
        next_col  = col_last ? '0 : cur_col + COL_W'(1);
        next_row  = !col_last ? cur_row : (row_last ? '0 : cur_row + ROW_W'(1));
        win_ok    = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
        win_first = (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));
        win_last  = row_last && col_last;
    end

    logic [PIX_W-1:0] line_a [IMG_W];
    logic [PIX_W-1:0] line_b [IMG_W];
    logic [PIX_W-1:0] new_u, new_c, new_b;
    logic [PIX_W-1:0] lft_u, lft_c, lft_b;
    logic [PIX_W-1:0] ctr_u, ctr_c, ctr_b;

    assign new_u = line_b[cur_col];
    assign new_c = line_a[cur_col];
    assign new_b = in_pix;

    // line_a holds the previous row, line_b the one before; contents are only trusted once row >= 2.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            line_a[cur_col] <= in_pix;
            line_b[cur_col] <= new_c;
            lft_u <= ctr_u;
            lft_c <= ctr_c;
            lft_b <= ctr_b;
            ctr_u <= new_u;
            ctr_c <= new_c;
            ctr_b <= new_b;
        end
    end

    function automatic logic signed [GRAD_W-1:0] widen(input logic [PIX_W-1:0] p);
        return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    logic signed [GRAD_W-1:0] gx, gy;

    always_comb begin
        gx = (widen(new_u) + (widen(new_c) <<< 1) + widen(new_b))
           - (widen(lft_u) + (widen(lft_c) <<< 1) + widen(lft_b));
        gy = (widen(lft_b) + (widen(ctr_b) <<< 1) + widen(new_b))
           - (widen(lft_u) + (widen(ctr_u) <<< 1) + widen(new_u));
    end

    logic                     s1_valid, s1_sof, s1_eof, s1_thr_en;
    logic signed [GRAD_W-1:0] s1_gx, s1_gy;
    logic [PIX_W-1:0]         s1_thr;
    logic                     s2_valid, s2_sof, s2_eof, s2_thr_en;
    logic [SQ_W-1:0]          s2_acc;
    logic [PIX_W-1:0]         s2_thr;
    logic                     s3_valid, s3_sof, s3_eof, s3_thr_en;
    logic [PIX_W-1:0]         s3_s, s3_thr;

    logic [GRAD_W-1:0] abs_gx, abs_gy;
    logic [SQ_W-1:0]   sq_sum, l1_sum;

    always_comb begin
        abs_gx = s1_gx[GRAD_W-1] ? $unsigned(-s1_gx) : $unsigned(s1_gx);
        abs_gy = s1_gy[GRAD_W-1] ? $unsigned(-s1_gy) : $unsigned(s1_gy);
        sq_sum = SQ_W'(abs_gx) * SQ_W'(abs_gx) + SQ_W'(abs_gy) * SQ_W'(abs_gy);
        l1_sum = SQ_W'(abs_gx) + SQ_W'(abs_gy);
    end

    logic [ROOT_W-1:0] root;
    logic [MAG_W-1:0]  mag, mag_q;
    logic [PIX_W-1:0]  scaled;

    sobel_isqrt #(
        .SQ_W   (SQ_W),
        .ROOT_W (ROOT_W)
    ) u_isqrt (
        .radicand (s2_acc),
        .root     (root)
    );

    // Quarter the magnitude and clamp so strong edges saturate instead of wrapping.
    always_comb begin
        mag    = USE_L1 ? s2_acc[MAG_W-1:0] : MAG_W'(root);
        mag_q  = mag >> 2;
        scaled = (mag_q > MAG_W'(PIX_MAX)) ? PIX_MAX : mag_q[PIX_W-1:0];
    end

    logic [PIX_W-1:0] level, shown;

    always_comb begin
        level = s3_thr_en ? ((s3_s >= s3_thr) ? PIX_MAX : '0) : s3_s;
        shown = (INVERT != 0) ? ~level : level;
    end

    // Every stage, counter and the output register freeze together while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_pix   <= '0;
        end else if (!stall) begin
            if (accept) begin
                col_cnt <= next_col;
                row_cnt <= next_row;
            end
            s1_valid  <= accept && win_ok;
            s1_sof    <= accept && win_first;
            s1_eof    <= accept && win_last;
            s1_gx     <= gx;
            s1_gy     <= gy;
            s1_thr_en <= thr_en;
            s1_thr    <= thr;

            s2_valid  <= s1_valid;
            s2_sof    <= s1_sof;
            s2_eof    <= s1_eof;
            s2_acc    <= USE_L1 ? l1_sum : sq_sum;
            s2_thr_en <= s1_thr_en;
            s2_thr    <= s1_thr;

            s3_valid  <= s2_valid;
            s3_sof    <= s2_sof;
            s3_eof    <= s2_eof;
            s3_s      <= scaled;
            s3_thr_en <= s2_thr_en;
            s3_thr    <= s2_thr;

            out_valid <= s3_valid;
            out_sof   <= s3_valid && s3_sof;
            out_eof   <= s3_valid && s3_eof;
            if (s3_valid) begin
                out_pix <= shown;
            end
        end
    end

endmodule
